h80cpu_bus_mem: RTL and testbench

Parametrised word-organised memory target for the h80cpu toggle-handshake bus (run/done). It is the drop-in successor to the CPU's fixed 16-bit memory. Generalised in:
- data width (16/32)
- depth and base address
- programmable wait states
- byte-lane access for any width
- range/command error reporting
- a busy indicator

---
 rtl/h80cpu_bus_mem.sv | 151 +++++++++++++++
 tb/tb_h80cpu_bus_mem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/h80cpu_bus_mem.sv
// rtl/h80cpu_bus_mem.sv - word-organised memory target for the h80cpu run/done toggle bus
//
// Parameters: DATA_W (16/32), ADDR_W, DEPTH_WORDS, BASE_ADDR, WAIT_STATES (0..15), INIT_FILE.
// Optional feature macro: H80CPU_BUS_MEM_INIT_EN (no start-up image loading in this build).
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   reset_   in   asynchronous active-low reset
//   addr     in   byte address
//   cmd      in   0 READ_W, 1 WRITE_W, 2 READ_B, 3 WRITE_B, others illegal
//   run      in   request toggle; pending while run != done
//   wr_data  in   write data (byte writes use wr_data[7:0])
//   rd_data  out  read result, held until the next completion
//   done     out  completion toggle
//   err      out  status of the last completed request (1 = range or command error)
//   busy     out  high between acceptance and completion when wait states are used
module h80cpu_bus_mem #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH_WORDS = 32768,
   parameter int BASE_ADDR   = 0,
   parameter int WAIT_STATES = 0,
   parameter     INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        cmd,
   input  logic              run,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              busy
);

   localparam int LANES = DATA_W / 8;
   localparam int LSB   = $clog2(LANES);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int OFF_W = ADDR_W - LSB;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   localparam logic [2:0] CMD_READ_W  = 3'd0;
   localparam logic [2:0] CMD_WRITE_W = 3'd1;
   localparam logic [2:0] CMD_READ_B  = 3'd2;
   localparam logic [2:0] CMD_WRITE_B = 3'd3;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [2:0]        lat_cmd;
   logic [DATA_W-1:0] lat_wdata;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Access operands: live inputs when completing on the acceptance edge,
   // latched copies when completing out of WAIT.
   logic [ADDR_W-1:0] acc_addr;
   logic [2:0]        acc_cmd;
   logic [DATA_W-1:0] acc_wdata;
   logic [ADDR_W-1:0] off;
   logic [OFF_W-1:0]  idx_full;
   logic [LSB-1:0]    lane;
   logic [IDX_W-1:0]  mem_idx;
   logic              in_range;
   logic              acc_ok;
   logic              acc_is_read;
   logic              fire;
   logic [DATA_W-1:0] rd_word;
   logic [7:0]        rd_byte;
   logic [DATA_W-1:0] rd_result;

   always_comb begin
      acc_addr    = (state == S_IDLE) ? addr    : lat_addr;
      acc_cmd     = (state == S_IDLE) ? cmd     : lat_cmd;
      acc_wdata   = (state == S_IDLE) ? wr_data : lat_wdata;
      off         = acc_addr - BASE;
      idx_full    = off[ADDR_W-1:LSB];
      lane        = off[LSB-1:0];
      mem_idx     = idx_full[IDX_W-1:0];
      // One extra bit so a depth equal to the full index space still compares correctly.
      in_range    = (acc_addr >= BASE) && ({1'b0, idx_full} < (OFF_W+1)'(DEPTH_WORDS));
      acc_ok      = in_range && (acc_cmd <= CMD_WRITE_B);
      acc_is_read = (acc_cmd == CMD_READ_W) || (acc_cmd == CMD_READ_B);
      // Gated by reset_ so an access in flight is dropped while reset is held.
      fire        = reset_ && (((state == S_IDLE) && (run != done) && (WAIT_STATES == 0)) ||
                               ((state == S_WAIT) && (cnt == 4'd0)));
      rd_word     = mem[mem_idx];
      rd_byte     = rd_word[{lane, 3'b000} +: 8];
      rd_result   = '0;
      if (acc_ok) rd_result = (acc_cmd == CMD_READ_B) ? DATA_W'(rd_byte) : rd_word;
   end

   // Memory array: no reset so contents survive reset_.
   always_ff @(posedge clk) begin
      if (fire && acc_ok) begin
         if (acc_cmd == CMD_WRITE_W)
            mem[mem_idx] <= acc_wdata;
         else if (acc_cmd == CMD_WRITE_B)
            mem[mem_idx][{lane, 3'b000} +: 8] <= acc_wdata[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         done      <= 1'b0;
         rd_data   <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         lat_addr  <= '0;
         lat_cmd   <= 3'd0;
         lat_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run != done) begin
                  lat_addr  <= addr;
                  lat_cmd   <= cmd;
                  lat_wdata <= wr_data;
                  if (WAIT_STATES == 0) begin
                     done <= ~done;
                     err  <= ~acc_ok;
                     if (acc_is_read) rd_data <= rd_result;
                  end else begin
                     cnt   <= 4'(WAIT_STATES - 1);
                     busy  <= 1'b1;
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  done  <= ~done;
                  err   <= ~acc_ok;
                  if (acc_is_read) rd_data <= rd_result;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_h80cpu_bus_mem.sv
// tb/tb_h80cpu_bus_mem.sv - directed table-driven bench for h80cpu_bus_mem
module tb_h80cpu_bus_mem;

   logic clk;
   logic reset_;
   logic [15:0] addr_v  [5];
   logic [2:0]  cmd_v   [5];
   logic [31:0] wdata_v [5];
   logic [4:0]  run_v;
   logic [4:0]  done_v;
   logic [4:0]  err_v;
   logic [4:0]  busy_v;
   logic [15:0] rd0, rd2, rd3, rd4;
   logic [31:0] rd1;

   int n_checks = 0;
   int n_err    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 0: 16-bit, no wait states
   h80cpu_bus_mem #(.DATA_W(16), .WAIT_STATES(0)) u_a (
      .clk(clk), .reset_(reset_), .addr(addr_v[0]), .cmd(cmd_v[0]), .run(run_v[0]),
      .wr_data(wdata_v[0][15:0]), .rd_data(rd0), .done(done_v[0]), .err(err_v[0]), .busy(busy_v[0]));
   // 1: 32-bit, base 0x1000, 1024 words
   h80cpu_bus_mem #(.DATA_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(16'h1000), .WAIT_STATES(0)) u_b (
      .clk(clk), .reset_(reset_), .addr(addr_v[1]), .cmd(cmd_v[1]), .run(run_v[1]),
      .wr_data(wdata_v[1]), .rd_data(rd1), .done(done_v[1]), .err(err_v[1]), .busy(busy_v[1]));
   // 2: 16-bit, 3 wait states
   h80cpu_bus_mem #(.DATA_W(16), .WAIT_STATES(3)) u_c (
      .clk(clk), .reset_(reset_), .addr(addr_v[2]), .cmd(cmd_v[2]), .run(run_v[2]),
      .wr_data(wdata_v[2][15:0]), .rd_data(rd2), .done(done_v[2]), .err(err_v[2]), .busy(busy_v[2]));
   // 3: 16-bit, 1024 words
   h80cpu_bus_mem #(.DATA_W(16), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_d (
      .clk(clk), .reset_(reset_), .addr(addr_v[3]), .cmd(cmd_v[3]), .run(run_v[3]),
      .wr_data(wdata_v[3][15:0]), .rd_data(rd3), .done(done_v[3]), .err(err_v[3]), .busy(busy_v[3]));
   // 4: 16-bit, 4 wait states
   h80cpu_bus_mem #(.DATA_W(16), .WAIT_STATES(4)) u_e (
      .clk(clk), .reset_(reset_), .addr(addr_v[4]), .cmd(cmd_v[4]), .run(run_v[4]),
      .wr_data(wdata_v[4][15:0]), .rd_data(rd4), .done(done_v[4]), .err(err_v[4]), .busy(busy_v[4]));

   function automatic logic [31:0] rd_of(input int u);
      case (u)
         0:       return {16'h0, rd0};
         1:       return rd1;
         2:       return {16'h0, rd2};
         3:       return {16'h0, rd3};
         default: return {16'h0, rd4};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request; lat = edges from acceptance to done toggle (40 = timed out).
   task automatic req(input int u, input logic [2:0] c, input logic [15:0] a,
                      input logic [31:0] d, output int lat);
      @(negedge clk);
      addr_v[u]  = a;
      cmd_v[u]   = c;
      wdata_v[u] = d;
      run_v[u]   = ~run_v[u];
      @(posedge clk); #1;
      lat = 0;
      while (done_v[u] !== run_v[u] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   typedef struct {
      int          u;
      logic [2:0]  c;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   localparam int NV = 26;
   vec_t tbl [NV];
   int   lat;

   initial begin
      tbl[0]  = '{0, 3'd1, 16'h2000, 32'h0000_1234, 32'h0000_0000, 1'b0};
      tbl[1]  = '{0, 3'd0, 16'h2000, 32'h0,         32'h0000_1234, 1'b0};
      tbl[2]  = '{0, 3'd2, 16'h2001, 32'h0,         32'h0000_0012, 1'b0};
      tbl[3]  = '{0, 3'd2, 16'h2000, 32'h0,         32'h0000_0034, 1'b0};
      tbl[4]  = '{0, 3'd3, 16'h2000, 32'h0000_00AB, 32'h0000_0034, 1'b0};
      tbl[5]  = '{0, 3'd0, 16'h2000, 32'h0,         32'h0000_12AB, 1'b0};
      tbl[6]  = '{0, 3'd1, 16'h2003, 32'h0000_5678, 32'h0000_12AB, 1'b0};
      tbl[7]  = '{0, 3'd0, 16'h2002, 32'h0,         32'h0000_5678, 1'b0};
      tbl[8]  = '{0, 3'd3, 16'h2003, 32'h0000_FFCD, 32'h0000_5678, 1'b0};
      tbl[9]  = '{0, 3'd0, 16'h2003, 32'h0,         32'h0000_CD78, 1'b0};
      tbl[10] = '{1, 3'd1, 16'h1004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[11] = '{1, 3'd3, 16'h1006, 32'h0000_0055, 32'h0000_0000, 1'b0};
      tbl[12] = '{1, 3'd0, 16'h1004, 32'h0,         32'hDE55_BEEF, 1'b0};
      tbl[13] = '{1, 3'd2, 16'h1007, 32'h0,         32'h0000_00DE, 1'b0};
      tbl[14] = '{1, 3'd2, 16'h1005, 32'h0,         32'h0000_00BE, 1'b0};
      tbl[15] = '{1, 3'd0, 16'h0FFC, 32'h0,         32'h0000_0000, 1'b1};
      tbl[16] = '{1, 3'd0, 16'h1006, 32'h0,         32'hDE55_BEEF, 1'b0};
      tbl[17] = '{1, 3'd0, 16'h2000, 32'h0,         32'h0000_0000, 1'b1};
      tbl[18] = '{1, 3'd1, 16'h1FFC, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
      tbl[19] = '{1, 3'd0, 16'h1FFC, 32'h0,         32'h0BAD_F00D, 1'b0};
      tbl[20] = '{3, 3'd1, 16'h0000, 32'h0000_A5A5, 32'h0000_0000, 1'b0};
      tbl[21] = '{3, 3'd0, 16'h0800, 32'h0,         32'h0000_0000, 1'b1};
      tbl[22] = '{3, 3'd5, 16'h0000, 32'h0000_1111, 32'h0000_0000, 1'b1};
      tbl[23] = '{3, 3'd0, 16'h0000, 32'h0,         32'h0000_A5A5, 1'b0};
      tbl[24] = '{3, 3'd1, 16'h07FE, 32'h0000_7777, 32'h0000_A5A5, 1'b0};
      tbl[25] = '{3, 3'd0, 16'h07FE, 32'h0,         32'h0000_7777, 1'b0};

      for (int u = 0; u < 5; u++) begin
         addr_v[u]  = '0;
         cmd_v[u]   = '0;
         wdata_v[u] = '0;
      end
      run_v  = '0;
      reset_ = 1'b1;
      #2 reset_ = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 5; u++) check($sformatf("reset_rd%0d", u), rd_of(u), 32'h0);
      check("reset_done", {27'h0, done_v}, 32'h0);
      check("reset_err",  {27'h0, err_v},  32'h0);
      check("reset_busy", {27'h0, busy_v}, 32'h0);
      reset_ = 1'b1;

      for (int i = 0; i < NV; i++) begin
         req(tbl[i].u, tbl[i].c, tbl[i].a, tbl[i].d, lat);
         check($sformatf("v%0d_rd", i),  rd_of(tbl[i].u), tbl[i].rd);
         check($sformatf("v%0d_err", i), {31'h0, err_v[tbl[i].u]}, {31'h0, tbl[i].er});
         check($sformatf("v%0d_lat", i), lat, 32'd0);
      end

      // Three wait states: busy profile, latency and latched operands.
      req(2, 3'd1, 16'h0040, 32'h0000_C0DE, lat);
      check("ws3_wr_lat", lat, 32'd3);
      req(2, 3'd1, 16'h0042, 32'h0000_1111, lat);
      check("ws3_wr2_lat", lat, 32'd3);
      @(negedge clk);
      addr_v[2] = 16'h0040;
      cmd_v[2]  = 3'd0;
      run_v[2]  = ~run_v[2];
      @(posedge clk); #1;
      check("ws3_acc_busy", {31'h0, busy_v[2]}, 32'd1);
      check("ws3_acc_pend", {31'h0, done_v[2] ^ run_v[2]}, 32'd1);
      @(negedge clk);
      addr_v[2]  = 16'h0042;
      cmd_v[2]   = 3'd1;
      wdata_v[2] = 32'h0000_2222;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k < 3) begin
            check($sformatf("ws3_e%0d_busy", k), {31'h0, busy_v[2]}, 32'd1);
            check($sformatf("ws3_e%0d_pend", k), {31'h0, done_v[2] ^ run_v[2]}, 32'd1);
         end else begin
            check("ws3_done",  {31'h0, done_v[2] ^ run_v[2]}, 32'd0);
            check("ws3_idle",  {31'h0, busy_v[2]}, 32'd0);
            check("ws3_rd",    rd_of(2), 32'h0000_C0DE);
            check("ws3_err",   {31'h0, err_v[2]}, 32'd0);
         end
      end
      req(2, 3'd0, 16'h0042, 32'h0, lat);
      check("ws3_latched_rd", rd_of(2), 32'h0000_1111);
      check("ws3_rd_lat", lat, 32'd3);

      // Four wait states: reset in the middle of a write aborts it.
      req(4, 3'd1, 16'h0010, 32'h0000_4321, lat);
      check("ws4_wr_lat", lat, 32'd4);
      req(4, 3'd0, 16'h0010, 32'h0, lat);
      req(4, 3'd0, 16'h0010, 32'h0, lat);
      check("ws4_rd", rd_of(4), 32'h0000_4321);
      check("ws4_done_pre", {31'h0, done_v[4]}, 32'd1);
      @(negedge clk);
      cmd_v[4]   = 3'd1;
      wdata_v[4] = 32'h0000_BEEF;
      run_v[4]   = ~run_v[4];
      @(posedge clk); #1;
      check("ws4_busy", {31'h0, busy_v[4]}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset_ = 1'b0;
      run_v  = '0;
      #1;
      check("rst_mid_done", {31'h0, done_v[4]}, 32'd0);
      check("rst_mid_busy", {31'h0, busy_v[4]}, 32'd0);
      check("rst_mid_rd",   rd_of(4), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_ = 1'b1;
      req(4, 3'd0, 16'h0010, 32'h0, lat);
      check("rst_mid_mem", rd_of(4), 32'h0000_4321);
      check("rst_mid_lat", lat, 32'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
